// File: rtl/cmp_state_filter.sv
// Debounces comparator less/equal/greater flags into a stable relation state.
// Optional per-class sample statistics are enabled by defining CMP_FILTER_STATS_EN.
module cmp_state_filter #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [1:0]       state_o,
    output logic             change_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] change_cnt_o,
    output logic [CNT_W-1:0] below_cnt_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [CNT_W-1:0] above_cnt_o
);

    // state      | meaning
    // ST_UNKNOWN | no relation accepted since reset
    // ST_BELOW   | A < B stable
    // ST_MATCH   | A == B stable
    // ST_ABOVE   | A > B stable
    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_BELOW   = 2'b01,
        ST_MATCH   = 2'b10,
        ST_ABOVE   = 2'b11
    } rel_e;

    localparam int unsigned      RUN_W   = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rel_e             r_state;
    rel_e             w_state_nxt;
    rel_e             r_cand;
    rel_e             w_cand_nxt;
    logic             r_cand_vld;
    logic             w_cand_vld_nxt;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic             r_change;
    logic             w_change_nxt;
    logic             r_illegal;
    logic             w_illegal_nxt;
    logic [CNT_W-1:0] r_change_cnt;
    logic [CNT_W-1:0] w_change_cnt_nxt;

    logic             w_onehot;
    rel_e             w_cls;

    assign w_onehot = (less ^ equal ^ greater) & ~(less & equal & greater);
    assign w_cls    = less ? ST_BELOW : (equal ? ST_MATCH : ST_ABOVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_UNKNOWN;
            r_cand       <= ST_UNKNOWN;
            r_cand_vld   <= 1'b0;
            r_run        <= '0;
            r_change     <= 1'b0;
            r_illegal    <= 1'b0;
            r_change_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_cand_vld   <= w_cand_vld_nxt;
            r_run        <= w_run_nxt;
            r_change     <= w_change_nxt;
            r_illegal    <= w_illegal_nxt;
            r_change_cnt <= w_change_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_cand_vld_nxt   = r_cand_vld;
        w_run_nxt        = r_run;
        w_change_nxt     = 1'b0;
        w_illegal_nxt    = 1'b0;
        w_change_cnt_nxt = r_change_cnt;

        if (sample_valid) begin
            if (!w_onehot) begin
                w_illegal_nxt  = 1'b1;
                w_cand_vld_nxt = 1'b0;
                w_cand_nxt     = ST_UNKNOWN;
                w_run_nxt      = '0;
            end else begin
                if (r_cand_vld && (r_cand == w_cls)) begin
                    w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);
                end else begin
                    w_cand_vld_nxt = 1'b1;
                    w_cand_nxt     = w_cls;
                    w_run_nxt      = RUN_W'(1);
                end
                // Candidate equals w_cls here, so acceptance compares the sample class directly
                if ((w_run_nxt == RUN_MAX) && (w_cls != r_state)) begin
                    w_state_nxt  = w_cls;
                    w_change_nxt = 1'b1;
                    if (r_change_cnt != CNT_MAX) begin
                        w_change_cnt_nxt = r_change_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign state_o      = r_state;
    assign change_o     = r_change;
    assign illegal_o    = r_illegal;
    assign change_cnt_o = r_change_cnt;

`ifdef CMP_FILTER_STATS_EN
    logic [CNT_W-1:0] r_below_cnt;
    logic [CNT_W-1:0] r_match_cnt;
    logic [CNT_W-1:0] r_above_cnt;
    logic             w_legal_smp;

    assign w_legal_smp = sample_valid & w_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_below_cnt <= '0;
            r_match_cnt <= '0;
            r_above_cnt <= '0;
        end else if (w_legal_smp) begin
            if ((w_cls == ST_BELOW) && (r_below_cnt != CNT_MAX)) begin
                r_below_cnt <= r_below_cnt + CNT_W'(1);
            end
            if ((w_cls == ST_MATCH) && (r_match_cnt != CNT_MAX)) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
            if ((w_cls == ST_ABOVE) && (r_above_cnt != CNT_MAX)) begin
                r_above_cnt <= r_above_cnt + CNT_W'(1);
            end
        end
    end

    assign below_cnt_o = r_below_cnt;
    assign match_cnt_o = r_match_cnt;
    assign above_cnt_o = r_above_cnt;
`else
    assign below_cnt_o = '0;
    assign match_cnt_o = '0;
    assign above_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cmp_state_filter.sv
// Scoreboard bench for cmp_state_filter: two instances (STABLE_CNT 4 and 1)
// checked every cycle against a behavioural model of the debounce rules.
module tb_cmp_state_filter;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_valid = 1'b0;
    logic less = 1'b0, equal = 1'b0, greater = 1'b0;

    logic [1:0]       st0, st1;
    logic             ch0, ch1, il0, il1;
    logic [CNT_W-1:0] cc0, cc1, bc0, bc1, mc0, mc1, ac0, ac1;

    always #5 clk = ~clk;

    cmp_state_filter #(.STABLE_CNT(4), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .less(less), .equal(equal), .greater(greater),
        .state_o(st0), .change_o(ch0), .illegal_o(il0), .change_cnt_o(cc0),
        .below_cnt_o(bc0), .match_cnt_o(mc0), .above_cnt_o(ac0));

    cmp_state_filter #(.STABLE_CNT(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .less(less), .equal(equal), .greater(greater),
        .state_o(st1), .change_o(ch1), .illegal_o(il1), .change_cnt_o(cc1),
        .below_cnt_o(bc1), .match_cnt_o(mc1), .above_cnt_o(ac1));

    typedef struct {
        int state;   // 0 unknown, 1 below, 2 match, 3 above
        int cand;    // -1 none
        int run;     // consecutive identical legal samples, unbounded
        bit chg;
        bit ill;
        int ccnt;
        int b, m, a;
    } mdl_t;

    mdl_t m0, m1;
    mdl_t q0[$];
    mdl_t q1[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.state = 0; r.cand = -1; r.run = 0; r.chg = 0; r.ill = 0;
        r.ccnt = 0; r.b = 0; r.m = 0; r.a = 0;
        return r;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, int stable, bit v, bit l, bit e, bit g);
        mdl_t r = s;
        int cls;
        r.chg = 0;
        r.ill = 0;
        if (!v) return r;
        if (int'(l) + int'(e) + int'(g) != 1) begin
            r.ill = 1; r.cand = -1; r.run = 0;
            return r;
        end
        cls = l ? 1 : (e ? 2 : 3);
        if (cls == r.cand) r.run = r.run + 1;
        else begin r.cand = cls; r.run = 1; end
`ifdef CMP_FILTER_STATS_EN
        if (cls == 1) r.b = sat_inc(r.b);
        if (cls == 2) r.m = sat_inc(r.m);
        if (cls == 3) r.a = sat_inc(r.a);
`endif
        if (r.run >= stable && r.cand != r.state) begin
            r.state = r.cand;
            r.chg   = 1;
            r.ccnt  = sat_inc(r.ccnt);
        end
        return r;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic chk_dut(string tag, mdl_t e, logic [1:0] st, logic ch, logic il,
                           logic [CNT_W-1:0] cc, logic [CNT_W-1:0] bc,
                           logic [CNT_W-1:0] mc, logic [CNT_W-1:0] ac);
        chk({tag, ".state"},   int'(st), e.state);
        chk({tag, ".change"},  int'(ch), int'(e.chg));
        chk({tag, ".illegal"}, int'(il), int'(e.ill));
        chk({tag, ".chg_cnt"}, int'(cc), e.ccnt);
        chk({tag, ".below"},   int'(bc), e.b);
        chk({tag, ".match"},   int'(mc), e.m);
        chk({tag, ".above"},   int'(ac), e.a);
    endtask

    // monitor: every cycle the DUT presents one registered result per pushed entry
    initial begin
        mdl_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk_dut("s4", e, st0, ch0, il0, cc0, bc0, mc0, ac0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk_dut("s1", e, st1, ch1, il1, cc1, bc1, mc1, ac1);
            end
        end
    end

    task automatic cycle(bit v, bit [2:0] f);
        sample_valid = v;
        {less, equal, greater} = f;
        @(posedge clk);
        #1;
        m0 = mdl_step(m0, 4, v, f[2], f[1], f[0]);
        m1 = mdl_step(m1, 1, v, f[2], f[1], f[0]);
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    function automatic bit [2:0] ab_flags(int a, int b);
        return {a < b, a == b, a > b};
    endfunction

    task automatic samples(int n, int a, int b);
        for (int i = 0; i < n; i++) cycle(1'b1, ab_flags(a, b));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'b000);
    endtask

    task automatic do_reset();
        mdl_t z;
        @(negedge clk);
        #1;
        sample_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        z = mdl_reset();
        chk_dut("rst_s4", z, st0, ch0, il0, cc0, bc0, mc0, ac0);
        chk_dut("rst_s1", z, st1, ch1, il1, cc1, bc1, mc1, ac1);
        m0 = z;
        m1 = z;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int a, b, tmo;
        bit [2:0] f;
        m0 = mdl_reset();
        m1 = mdl_reset();
        do_reset();

        samples(4, 10, 12);                       // BELOW accepted on 4th edge
        idle(2);
        do_reset();

        for (int i = 0; i < 10; i++) begin        // alternating, never stable
            if (i % 2 == 0) samples(1, 15, 11);
            else            samples(1, 10, 10);
        end
        idle(1);
        do_reset();

        samples(3, 7, 7);                         // run broken by illegal sample
        cycle(1'b1, 3'b110);
        samples(4, 7, 7);
        idle(1);
        do_reset();

        samples(2, 15, 11);                       // gaps do not break a run
        idle(5);
        samples(2, 15, 11);
        idle(1);
        do_reset();

        samples(3, 10, 12);                       // reset discards partial run
        do_reset();
        samples(4, 10, 12);
        idle(1);
        do_reset();

        samples(20, 5, 5);                        // statistics saturation
        idle(1);

        a = 3; b = 3;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 15) begin
                a = $urandom_range(15);
                b = $urandom_range(15);
            end
            if ($urandom_range(99) < 8) begin
                case ($urandom_range(4))
                    0: f = 3'b000;
                    1: f = 3'b011;
                    2: f = 3'b101;
                    3: f = 3'b110;
                    default: f = 3'b111;
                endcase
            end else begin
                f = ab_flags(a, b);
            end
            cycle($urandom_range(99) < 75, f);
            if (i == 1000) do_reset();
        end

        tmo = 0;
        while ((q0.size() > 0 || q1.size() > 0) && tmo < 10) begin
            @(negedge clk);
            #1;
            tmo++;
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left expected 0", q0.size() + q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
